// File: rtl/bcd_updown_timer_pkg.sv
// Shared constants for the BCD timer: digit width, active-low 7-segment codes (g..a),
// and a single-digit decoder that shows blank for non-decimal values.
package bcd_updown_timer_pkg;

  localparam int BCD_DIGIT_W = 4;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_decode(input logic [BCD_DIGIT_W-1:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bcd_decade.sv
// One BCD decade register with load (clamped to 9), clear, increment and decrement.
// Priority: rst > load > clear > inc > dec; carry/borrow ripple to the next decade.
module bcd_decade
  import bcd_updown_timer_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   inc,
  input  logic                   dec,
  input  logic                   clear,
  input  logic                   load,
  input  logic [BCD_DIGIT_W-1:0] load_d,
  output logic [BCD_DIGIT_W-1:0] q,
  output logic                   carry_out,
  output logic                   borrow_out
);

  always_ff @(posedge clk) begin
    if (rst)        q <= 4'd0;
    else if (load)  q <= (load_d > 4'd9) ? 4'd9 : load_d;
    else if (clear) q <= 4'd0;
    else if (inc)   q <= (q == 4'd9) ? 4'd0 : q + 4'd1;
    else if (dec)   q <= (q == 4'd0) ? 4'd9 : q - 4'd1;
  end

  assign carry_out  = inc & (q == 4'd9);
  assign borrow_out = dec & (q == 4'd0);

endmodule

// File: rtl/bcd_updown_timer.sv
// N-digit BCD up/down timer stepping once per TICK_DIV clocks, with modulo limit,
// load, pause, terminal-count pulse and optional leading-zero blanking on 7-seg outputs.
module bcd_updown_timer
  import bcd_updown_timer_pkg::*;
#(
  parameter int DIGITS   = 3,
  parameter int TICK_DIV = 50_000_000,
  parameter int TICK_W   = 26,
  parameter int BLANK_LZ = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                up,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic [4*DIGITS-1:0] limit,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic [7*DIGITS-1:0] seg,
  output logic                tick,
  output logic                tc
);

  localparam logic [TICK_W-1:0] PRESC_MAX = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0]   presc;
  logic [4*DIGITS-1:0] lim_c;
  logic                step, wrap_up, wrap_dn, overflow, lz;
  logic [DIGITS:0]     inc_c, dec_c;

  assign tick = en & (presc == PRESC_MAX);
  assign step = tick & ~load;

  always_ff @(posedge clk) begin
    if (rst)       presc <= '0;
    else if (load) presc <= '0;
    else if (en)   presc <= tick ? '0 : presc + 1'b1;
  end

  always_comb begin
    lim_c = limit;
    for (int i = 0; i < DIGITS; i++)
      if (limit[4*i +: 4] > 4'd9) lim_c[4*i +: 4] = 4'd9;
  end

  // Digits never exceed 9, so a plain binary compare orders BCD values correctly.
  assign wrap_up = up & (bcd_out >= lim_c);
  assign wrap_dn = ~up & (bcd_out == '0);

  assign inc_c[0] = step & up & ~wrap_up;
  assign dec_c[0] = step & ~up & ~wrap_dn;

  for (genvar i = 0; i < DIGITS; i++) begin : g_decade
    bcd_decade u_decade (
      .clk        (clk),
      .rst        (rst),
      .inc        (inc_c[i]),
      .dec        (dec_c[i]),
      .clear      (step & wrap_up),
      .load       (load | (step & wrap_dn)),
      .load_d     (load ? load_val[4*i +: 4] : lim_c[4*i +: 4]),
      .q          (bcd_out[4*i +: 4]),
      .carry_out  (inc_c[i+1]),
      .borrow_out (dec_c[i+1])
    );
  end

  // Chain overflow cannot occur below the wrap checks; treating it as a wrap keeps tc honest anyway.
  assign overflow = inc_c[DIGITS] | dec_c[DIGITS];

  always_ff @(posedge clk) begin
    if (rst)       tc <= 1'b0;
    else if (load) tc <= 1'b0;
    else           tc <= step & (wrap_up | wrap_dn | overflow);
  end

  always_comb begin
    seg = '0;
    lz  = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lz = lz & (bcd_out[4*i +: 4] == 4'd0);
      if ((BLANK_LZ != 0) && (i > 0) && lz) seg[7*i +: 7] = SEG_BLANK;
      else                                  seg[7*i +: 7] = seg_decode(bcd_out[4*i +: 4]);
    end
  end

endmodule

// File: tb/tb_bcd_updown_timer.sv
// Directed-vector bench: two instances (no blanking / leading-zero blanking) share stimulus.
module tb_bcd_updown_timer;

  localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S5 = 7'h12, S7 = 7'h78, S9 = 7'h10, SB = 7'h7F;

  logic        clk = 1'b0;
  logic        rst = 1'b1, en = 1'b0, up = 1'b1, load = 1'b0;
  logic [11:0] load_val = '0, limit = 12'h999;
  logic [11:0] bcd_a, bcd_b;
  logic [20:0] seg_a, seg_b, exp_seg;
  logic        tick_a, tick_b, tc_a, tc_b;

  int n_vec = 0;
  int n_err = 0;
  int n_tick;

  always #5 clk = ~clk;

  bcd_updown_timer #(.DIGITS(3), .TICK_DIV(4), .TICK_W(3), .BLANK_LZ(0)) u_dut_a (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .limit(limit), .bcd_out(bcd_a), .seg(seg_a), .tick(tick_a), .tc(tc_a));

  bcd_updown_timer #(.DIGITS(3), .TICK_DIV(4), .TICK_W(3), .BLANK_LZ(1)) u_dut_b (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .limit(limit), .bcd_out(bcd_b), .seg(seg_b), .tick(tick_b), .tc(tc_b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance n clocks; inputs change and outputs are sampled 1ns after the edge.
  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [11:0] v);
    load_val = v;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
  endtask

  initial begin
    // Reset
    cyc(2);
    chk("rst_bcd", bcd_a, 12'h000);
    chk("rst_tc", tc_a, 0);
    exp_seg = {S0, S0, S0};
    chk("rst_seg_a", seg_a, exp_seg);
    exp_seg = {SB, SB, S0};
    chk("rst_seg_b", seg_b, exp_seg);

    // Count up from reset, limit 999
    rst = 1'b0; en = 1'b1; up = 1'b1; limit = 12'h999;
    cyc(3);
    chk("first_tick", tick_a, 1);
    chk("pre_step_bcd", bcd_a, 12'h000);
    cyc(1);
    chk("step1_bcd", bcd_a, 12'h001);
    chk("step1_tick", tick_a, 0);
    cyc(32);
    chk("up_009", bcd_a, 12'h009);
    exp_seg = {S0, S0, S9};
    chk("seg_009_a", seg_a, exp_seg);
    exp_seg = {SB, SB, S9};
    chk("seg_009_b", seg_b, exp_seg);
    cyc(4);
    chk("up_010", bcd_a, 12'h010);
    n_tick = 0;
    for (int k = 0; k < 8; k++) begin
      cyc(1);
      if (tick_a) n_tick++;
    end
    chk("tick_rate", n_tick, 2);
    chk("up_012", bcd_a, 12'h012);

    // Up wrap 998 -> 999 -> 000 with tc
    do_load(12'h998);
    chk("load_998", bcd_a, 12'h998);
    cyc(4);
    chk("up_999", bcd_a, 12'h999);
    chk("tc_before_wrap", tc_a, 0);
    cyc(4);
    chk("wrap_000", bcd_a, 12'h000);
    chk("wrap_tc", tc_a, 1);
    cyc(1);
    chk("wrap_tc_1cyc", tc_a, 0);

    // Down, limit 059
    up = 1'b0; limit = 12'h059;
    do_load(12'h001);
    cyc(4);
    chk("dn_000", bcd_a, 12'h000);
    chk("dn_000_tc", tc_a, 0);
    cyc(4);
    chk("dn_wrap_059", bcd_a, 12'h059);
    chk("dn_wrap_tc", tc_a, 1);
    cyc(1);
    chk("dn_tc_1cyc", tc_a, 0);
    do_load(12'h010);
    cyc(4);
    chk("dn_borrow_009", bcd_a, 12'h009);

    // Pause mid-count at 123
    up = 1'b1; limit = 12'h999;
    do_load(12'h123);
    cyc(2);
    en = 1'b0;
    cyc(10);
    chk("pause_bcd", bcd_a, 12'h123);
    chk("pause_tick", tick_a, 0);
    en = 1'b1;
    cyc(1);
    chk("resume_phase_tick", tick_a, 1);
    cyc(1);
    chk("resume_124", bcd_a, 12'h124);
    en = 1'b0;
    do_load(12'h456);
    chk("load_in_pause", bcd_a, 12'h456);

    // Clamp and out-of-range
    do_load(12'h00F);
    chk("clamp_009", bcd_a, 12'h009);
    en = 1'b1; limit = 12'h100;
    do_load(12'h500);
    cyc(4);
    chk("oor_wrap", bcd_a, 12'h000);
    chk("oor_tc", tc_a, 1);
    limit = 12'h0FF;
    do_load(12'h098);
    cyc(4);
    chk("lim_clamp_099", bcd_a, 12'h099);
    cyc(4);
    chk("lim_clamp_wrap", bcd_a, 12'h000);
    chk("lim_clamp_tc", tc_a, 1);

    // Leading-zero blanking
    en = 1'b0;
    do_load(12'h007);
    exp_seg = {SB, SB, S7};
    chk("blank_007_b", seg_b, exp_seg);
    exp_seg = {S0, S0, S7};
    chk("noblank_007_a", seg_a, exp_seg);
    do_load(12'h105);
    exp_seg = {S1, S0, S5};
    chk("blank_105_b", seg_b, exp_seg);
    do_load(12'h000);
    exp_seg = {SB, SB, S0};
    chk("blank_000_b", seg_b, exp_seg);

    // Reset asserted on a wrapping tick
    en = 1'b1; limit = 12'h999;
    do_load(12'h999);
    cyc(3);
    chk("rst_tick_pre", tick_b, 1);
    rst = 1'b1;
    cyc(1);
    chk("rst_mid_bcd", bcd_b, 12'h000);
    chk("rst_mid_tc", tc_b, 0);
    chk("rst_mid_tick", tick_b, 0);
    rst = 1'b0;
    cyc(1);
    chk("rst_after_tc", tc_b, 0);
    cyc(2);
    chk("rst_presc_tick", tick_b, 1);
    chk("rst_presc_bcd", bcd_b, 12'h000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
